// File: rtl/game_end_scanner_if.sv
// Request/result bundle between the game-control FSM (master) and the
// game-end scanner (slave).
interface game_end_scanner_if #(
  parameter int BOARD_N = 3
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int CNT_W = $clog2(CELLS + 1);

  logic                 start_i;
  logic [2*CELLS-1:0]   board_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 game_end_o;
  logic                 win_o;
  logic                 tie_o;
  logic                 winner_o;
  logic [1:0]           win_dir_o;
  logic [CELLS-1:0]     win_mask_o;
  logic [CNT_W-1:0]     occupied_o;

  modport master (
    output start_i, board_i,
    input  busy_o, done_o, game_end_o, win_o, tie_o, winner_o,
           win_dir_o, win_mask_o, occupied_o
  );

  modport slave (
    input  start_i, board_i,
    output busy_o, done_o, game_end_o, win_o, tie_o, winner_o,
           win_dir_o, win_mask_o, occupied_o
  );
endinterface

// File: rtl/game_end_scanner.sv
// Sequential N x N, K-in-a-row game-end detector: snapshots the board and
// walks every (anchor cell, direction) window, one per clock.
module game_end_scanner #(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  game_end_scanner_if.slave  bus
);
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int CNT_W = $clog2(CELLS + 1);
  localparam int RC_W  = $clog2(BOARD_N);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [2*CELLS-1:0] snap;
  logic [RC_W-1:0]    row, col;
  logic [1:0]         dir;
  logic               last_pair, win_hit, anchor_p, finish;
  logic [CELLS-1:0]   mask_c;
  logic [CNT_W-1:0]   occ_c;

  logic               win_q, tie_q, winner_q;
  logic [1:0]         dir_q;
  logic [CELLS-1:0]   mask_q;
  logic [CNT_W-1:0]   occ_q;

  // Row/col/dir counters stand in for the pair index p = (row*N+col)*4 + dir.
  assign last_pair = (row == RC_W'(BOARD_N - 1)) && (col == RC_W'(BOARD_N - 1)) && (dir == 2'd3);
  assign finish    = win_hit || last_pair;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_i) state_nx = SCAN;
      SCAN:    if (finish)      state_nx = DONE;
      DONE:                     state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state != IDLE);
    bus.done_o = (state == DONE);
  end

  always_comb begin
    int dr, dc, rr, cc, ci, ai;
    logic valid, all_same;
    ai       = int'(row) * BOARD_N + int'(col);
    anchor_p = snap[2*ai];
    case (dir)
      2'd0:    begin dr = 0; dc =  1; end
      2'd1:    begin dr = 1; dc =  0; end
      2'd2:    begin dr = 1; dc =  1; end
      default: begin dr = 1; dc = -1; end
    endcase
    case (dir)
      2'd0:    valid = (int'(col) + WIN_K <= BOARD_N);
      2'd1:    valid = (int'(row) + WIN_K <= BOARD_N);
      2'd2:    valid = (int'(col) + WIN_K <= BOARD_N) && (int'(row) + WIN_K <= BOARD_N);
      default: valid = (int'(col) >= WIN_K - 1) && (int'(row) + WIN_K <= BOARD_N);
    endcase
    all_same = 1'b1;
    mask_c   = '0;
    rr = 0; cc = 0; ci = 0;
    for (int unsigned k = 0; k < unsigned'(WIN_K); k++) begin
      rr = int'(row) + int'(k) * dr;
      cc = int'(col) + int'(k) * dc;
      if (rr >= 0 && rr < BOARD_N && cc >= 0 && cc < BOARD_N) begin
        ci         = rr * BOARD_N + cc;
        mask_c[ci] = 1'b1;
        if (!snap[2*ci+1] || (snap[2*ci] != anchor_p)) all_same = 1'b0;
      end else begin
        all_same = 1'b0;
      end
    end
    win_hit = valid && all_same;
  end

  always_comb begin
    occ_c = '0;
    for (int unsigned i = 0; i < unsigned'(CELLS); i++)
      occ_c = occ_c + CNT_W'(snap[2*i+1]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap     <= '0;
      row      <= '0;
      col      <= '0;
      dir      <= '0;
      win_q    <= 1'b0;
      tie_q    <= 1'b0;
      winner_q <= 1'b0;
      dir_q    <= '0;
      mask_q   <= '0;
      occ_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          snap     <= bus.board_i;
          row      <= '0;
          col      <= '0;
          dir      <= '0;
          win_q    <= 1'b0;
          tie_q    <= 1'b0;
          winner_q <= 1'b0;
          dir_q    <= '0;
          mask_q   <= '0;
          occ_q    <= '0;
        end
        SCAN: if (finish) begin
          win_q    <= win_hit;
          tie_q    <= !win_hit && (occ_c == CNT_W'(CELLS));
          winner_q <= win_hit && anchor_p;
          dir_q    <= win_hit ? dir : 2'd0;
          mask_q   <= win_hit ? mask_c : '0;
          occ_q    <= occ_c;
        end else begin
          dir <= dir + 2'd1;
          if (dir == 2'd3) begin
            if (col == RC_W'(BOARD_N - 1)) begin
              col <= '0;
              row <= row + RC_W'(1);
            end else begin
              col <= col + RC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.win_o      = win_q;
  assign bus.tie_o      = tie_q;
  assign bus.game_end_o = win_q | tie_q;
  assign bus.winner_o   = winner_q;
  assign bus.win_dir_o  = dir_q;
  assign bus.win_mask_o = mask_q;
  assign bus.occupied_o = occ_q;
endmodule

// File: tb/tb_game_end_scanner.sv
// Scoreboard bench for game_end_scanner: 3x3/K=3 and 5x5/K=4 instances,
// directed boards with hand-computed results and done-cycle latency.
module tb_game_end_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_end_scanner_if #(.BOARD_N(3)) b3 ();
  game_end_scanner_if #(.BOARD_N(5)) b5 ();

  game_end_scanner #(.BOARD_N(3), .WIN_K(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
  game_end_scanner #(.BOARD_N(5), .WIN_K(4)) dut5 (.clk_i(clk), .rst_i(rst), .bus(b5.slave));

  typedef struct {
    logic        win;
    logic        tie;
    logic        winner;
    logic [1:0]  dir;
    logic [63:0] mask;
    int          occ;
    int          p;
    int          done_cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q5[$];
  exp_t e3, e5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic t, input logic wn, input logic [1:0] d,
                              input logic [63:0] m, input int o, input int p);
    exp_t e;
    e.win = w; e.tie = t; e.winner = wn; e.dir = d; e.mask = m; e.occ = o; e.p = p; e.done_cyc = 0;
    return e;
  endfunction

  // Monitors: pop the expected result whenever a done pulse is seen.
  always @(negedge clk) begin
    if (b3.done_o === 1'b1) begin
      if (q3.size() == 0) chk("dut3_unexpected_done", 64'(b3.done_o), 64'd0);
      else begin
        e3 = q3.pop_front();
        chk("dut3_done_cycle", 64'(cyc), 64'(e3.done_cyc));
        chk("dut3_win", 64'(b3.win_o), 64'(e3.win));
        chk("dut3_tie", 64'(b3.tie_o), 64'(e3.tie));
        chk("dut3_game_end", 64'(b3.game_end_o), 64'(e3.win | e3.tie));
        chk("dut3_winner", 64'(b3.winner_o), 64'(e3.winner));
        chk("dut3_dir", 64'(b3.win_dir_o), 64'(e3.dir));
        chk("dut3_mask", 64'(b3.win_mask_o), e3.mask);
        chk("dut3_occupied", 64'(b3.occupied_o), 64'(e3.occ));
      end
    end
  end

  always @(negedge clk) begin
    if (b5.done_o === 1'b1) begin
      if (q5.size() == 0) chk("dut5_unexpected_done", 64'(b5.done_o), 64'd0);
      else begin
        e5 = q5.pop_front();
        chk("dut5_done_cycle", 64'(cyc), 64'(e5.done_cyc));
        chk("dut5_win", 64'(b5.win_o), 64'(e5.win));
        chk("dut5_tie", 64'(b5.tie_o), 64'(e5.tie));
        chk("dut5_winner", 64'(b5.winner_o), 64'(e5.winner));
        chk("dut5_dir", 64'(b5.win_dir_o), 64'(e5.dir));
        chk("dut5_mask", 64'(b5.win_mask_o), e5.mask);
        chk("dut5_occupied", 64'(b5.occupied_o), 64'(e5.occ));
      end
    end
  end

  task automatic check_zero3(input string tag);
    chk({tag, "_busy"}, 64'(b3.busy_o), 64'd0);
    chk({tag, "_done"}, 64'(b3.done_o), 64'd0);
    chk({tag, "_win"}, 64'(b3.win_o), 64'd0);
    chk({tag, "_tie"}, 64'(b3.tie_o), 64'd0);
    chk({tag, "_game_end"}, 64'(b3.game_end_o), 64'd0);
    chk({tag, "_winner"}, 64'(b3.winner_o), 64'd0);
    chk({tag, "_dir"}, 64'(b3.win_dir_o), 64'd0);
    chk({tag, "_mask"}, 64'(b3.win_mask_o), 64'd0);
    chk({tag, "_occupied"}, 64'(b3.occupied_o), 64'd0);
  endtask

  // Start pulse sampled at E0; done is seen at the negedge after E(p+1).
  task automatic run3(input logic [17:0] b, input exp_t e, input string tag);
    bit seen;
    @(negedge clk);
    b3.board_i = b; b3.start_i = 1'b1;
    e.done_cyc = cyc + e.p + 2;
    q3.push_back(e);
    @(negedge clk);
    b3.start_i = 1'b0; b3.board_i = '1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b3.done_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) chk({tag, "_timeout"}, 64'(b3.done_o), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_hold_win"}, 64'(b3.win_o), 64'(e.win));
    chk({tag, "_hold_mask"}, 64'(b3.win_mask_o), e.mask);
  endtask

  task automatic run5(input logic [49:0] b, input exp_t e, input string tag);
    bit seen;
    @(negedge clk);
    b5.board_i = b; b5.start_i = 1'b1;
    e.done_cyc = cyc + e.p + 2;
    q5.push_back(e);
    @(negedge clk);
    b5.start_i = 1'b0; b5.board_i = '0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (b5.done_o === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) chk({tag, "_timeout"}, 64'(b5.done_o), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  localparam logic [17:0] BRD_ROW0  = 18'b00_00_00_00_00_00_11_11_11;
  localparam logic [17:0] BRD_ANTI  = 18'b00_00_10_00_10_00_10_00_00;
  localparam logic [17:0] BRD_TIE   = 18'b11_11_10_10_10_11_11_10_11;
  localparam logic [17:0] BRD_RC    = 18'b00_00_11_00_00_11_11_11_11;
  localparam logic [17:0] BRD_UNOCC = 18'b00_00_00_00_00_00_01_11_11;

  initial begin
    logic [49:0] brd5;
    logic [63:0] m5;
    b3.start_i = 1'b0; b3.board_i = '0;
    b5.start_i = 1'b0; b5.board_i = '0;
    repeat (3) @(negedge clk);
    check_zero3("reset");
    rst = 1'b0;
    @(negedge clk);

    run3(BRD_ROW0,  mk(1, 0, 1, 2'd0, 64'h007, 3, 0),  "row0");
    run3(BRD_ANTI,  mk(1, 0, 0, 2'd3, 64'h054, 3, 11), "anti");
    run3(BRD_TIE,   mk(0, 1, 0, 2'd0, 64'h000, 9, 35), "tie");
    run3(BRD_RC,    mk(1, 0, 1, 2'd0, 64'h007, 5, 0),  "row_col");
    run3(BRD_UNOCC, mk(0, 0, 0, 2'd0, 64'h000, 2, 35), "unocc");

    // Mid-scan: ignored start at E5, async reset at E10, then a fresh scan.
    @(negedge clk);
    b3.board_i = BRD_TIE; b3.start_i = 1'b1;
    @(negedge clk);
    b3.start_i = 1'b0;
    repeat (4) @(negedge clk);
    b3.board_i = BRD_ROW0; b3.start_i = 1'b1;
    @(negedge clk);
    b3.start_i = 1'b0;
    chk("ignored_start_busy", 64'(b3.busy_o), 64'd1);
    chk("ignored_start_no_done", 64'(b3.done_o), 64'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero3("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run3(BRD_ROW0, mk(1, 0, 1, 2'd0, 64'h007, 3, 0), "after_abort");

    brd5 = '0;
    m5   = '0;
    foreach (brd5[i]) if (i == 0) begin
      brd5[2*9 +: 2]  = 2'b10; brd5[2*14 +: 2] = 2'b10;
      brd5[2*19 +: 2] = 2'b10; brd5[2*24 +: 2] = 2'b10;
    end
    m5[9] = 1'b1; m5[14] = 1'b1; m5[19] = 1'b1; m5[24] = 1'b1;
    run5(brd5, mk(1, 0, 0, 2'd1, m5, 4, 37), "n5_col4");

    brd5 = '0;
    brd5[1:0] = 2'b11; brd5[3:2] = 2'b11; brd5[5:4] = 2'b11;
    run5(brd5, mk(0, 0, 0, 2'd0, 64'd0, 3, 99), "n5_three_short");

    chk("q3_drained", 64'(q3.size()), 64'd0);
    chk("q5_drained", 64'(q5.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/game_end_scanner.md
Name: game_end_scanner

Overview:
- Sequential, parametrised game-end detector for an N x N board with a K-in-a-row win rule. Generalises the combinational 3x3 end detector.
- On a start request it snapshots the board, then scans every (anchor cell, direction) window, one per clock.
- Reports win/tie, winning player, winning direction, a per-cell winning mask and the occupied-cell count.
- Sits between the board register file and the game-control FSM, which issues start_i after each committed move.

Parameters:
BOARD_N, 3, board side length; legal range 3..8
WIN_K, 3, cells in a row needed to win; legal range 2..BOARD_N
CELLS (derived), BOARD_N*BOARD_N, cell count
CNT_W (derived), $clog2(CELLS+1), width of occupied count

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  scan request; sampled only in IDLE
board_i  in  2*CELLS  cell idx = row*BOARD_N+col at bits [2*idx+1:2*idx]; bit1 = occupied, bit0 = player id
busy_o  out  1  high while in SCAN or DONE
done_o  out  1  one-cycle pulse; results valid from this cycle onward
game_end_o  out  1  win_o | tie_o
win_o  out  1  a winning window was found
tie_o  out  1  all cells occupied and no win
winner_o  out  1  player id of the winning window; 0 if no win
win_dir_o  out  2  0 horizontal, 1 vertical, 2 diag down-right, 3 diag down-left
win_mask_o  out  CELLS  bit idx set for each cell of the winning window
occupied_o  out  CNT_W  number of cells with bit1 = 1 in the snapshot

Behaviour:
- Reset (async, any state): state = IDLE; all outputs and the snapshot are 0.
- FSM states:
  - IDLE: on start_i=1, the edge (E0) captures board_i into the snapshot, clears all result outputs, sets pair index p = 0, and moves to SCAN.
  - SCAN: pair p = idx*4 + dir, idx = 0..CELLS-1 (row-major), dir = 0..3. The window is evaluated combinationally from the snapshot at edge E(p+1).
    - If the window wins, or p = 4*CELLS-1, that edge registers the results and moves to DONE.
    - Otherwise p increments.
  - DONE: done_o = 1 for exactly this cycle; the next edge returns to IDLE.
- Window validity, with anchor (r,c); cells step by (0,+1), (+1,0), (+1,+1) or (+1,-1):
  - dir 0 valid iff c+WIN_K <= BOARD_N.
  - dir 1 valid iff r+WIN_K <= BOARD_N.
  - dir 2 valid iff both of the above.
  - dir 3 valid iff c >= WIN_K-1 and r+WIN_K <= BOARD_N.
  - Invalid pairs evaluate as no-win but still consume one cycle. This gives fixed, predictable latency.
- Win condition: window valid, all WIN_K cells have bit1 = 1, and all have equal bit0.
- Latency: if the first winning pair is p, done_o is high in the cycle after E(p+1). With no win, done_o is high after E(4*CELLS); 36 edges for the 3x3 default.
- Multiple winning windows: only the first in scan order is reported. win_mask_o contains only that window.
- occupied_o and tie_o are computed from the snapshot and registered together with the other results.
- tie_o = 1 only when occupied_o = CELLS and no win. A full board containing a win reports win_o = 1, tie_o = 0.
- Result outputs hold their values from done_o until the next accepted start_i, which clears them at E0.
- start_i while busy_o = 1 is ignored; it is not queued.
- board_i changes after E0 have no effect on the current scan.
- Cells with bit1 = 0 never contribute to a win, regardless of bit0.
- Reset asserted mid-SCAN aborts immediately. No done_o pulse follows; the next start_i after reset release begins a fresh scan.

Test Plan:
1. BOARD_N=3: cells 0,1,2 = 2'b11, others 0, start_i pulse → p=0 wins. done_o high after E1; win_o=1, winner_o=1, win_dir_o=0, win_mask_o=9'b000000111, occupied_o=3, tie_o=0.
2. Cells 2,4,6 = 2'b10 (anti-diagonal, player 0) → p=11. done_o after E12; winner_o=0, win_dir_o=3, win_mask_o=9'b001010100.
3. Full board, rows X O X / X O O / O X X (X=2'b11, O=2'b10) → done_o after E36; win_o=0, tie_o=1, game_end_o=1, occupied_o=9, win_mask_o=0.
4. Row 0 and column 0 both player 1 (cells 0,1,2,3,6) → first window reported: win_dir_o=0, win_mask_o=9'b000000111, done_o after E1.
5. BOARD_N=5, WIN_K=4: cells 9,14,19,24 = 2'b10 → p=37. done_o after E38; win_dir_o=1, mask bits 9,14,19,24 only.
6. Start a no-win scan:
   - pulse start_i at E5 → ignored; busy_o stays 1.
   - assert rst_i at E10 → all outputs 0 immediately; no done_o pulse.
   - release rst_i, then start on the case 1 board → same results as case 1.
